// File: rtl/yarvi_ls_issue_pkg.sv
// Shared types and widths for the load/store issue slice (yarvi_ls_issue).
// Supplies VMSB/XMSB/YARVI_LS_ENTRY_W defaults when yarvi.h has not been seen.
`ifndef VMSB
`define VMSB 63
`endif
`ifndef XMSB
`define XMSB 63
`endif
`ifndef YARVI_LS_ENTRY_W
`define YARVI_LS_ENTRY_W (1 + (`VMSB + 1) + (`XMSB + 1) + 2 + 5 + 1)
`endif

package yarvi_ls_issue_pkg;

  localparam int VW = `VMSB + 1;
  localparam int XW = `XMSB + 1;
  localparam int ENTRY_W = `YARVI_LS_ENTRY_W;

  // One queued memory request; tag is already the read tag (0 for stores / x0).
  typedef struct packed {
    logic          we;
    logic [VW-1:0] address;
    logic [XW-1:0] data;
    logic [1:0]    sizelg2;
    logic [4:0]    tag;
    logic          signextend;
  } ls_entry_t;

  function automatic logic [4:0] read_tag(input logic we, input logic [4:0] rd);
    return we ? 5'd0 : rd;
  endfunction

endpackage

// File: rtl/yarvi_ls_issue_if.sv
// Execute-side request and memory-stage request/response bundle for yarvi_ls_issue.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high;
// the offering side holds its fields stable while valid is high and ready is low.
interface yarvi_ls_issue_if;
  import yarvi_ls_issue_pkg::*;

  logic          req_valid;
  logic          req_ready;
  logic          req_writeenable;
  logic [VW-1:0] req_address;
  logic [XW-1:0] req_writedata;
  logic [1:0]    req_sizelg2;
  logic [4:0]    req_rd;
  logic          req_signextend;

  logic          mem_valid;
  logic          mem_writeenable;
  logic [VW-1:0] mem_address;
  logic [XW-1:0] mem_writedata;
  logic [1:0]    mem_sizelg2;
  logic [4:0]    mem_readtag;
  logic          mem_readsignextend;
  logic          me_ready;

  logic          me_readdatavalid;
  logic [4:0]    me_readdatatag;
  logic [XW-1:0] me_readdata;

  modport slave (
    input  req_valid, req_writeenable, req_address, req_writedata,
           req_sizelg2, req_rd, req_signextend,
    output req_ready,
    output mem_valid, mem_writeenable, mem_address, mem_writedata,
           mem_sizelg2, mem_readtag, mem_readsignextend,
    input  me_ready, me_readdatavalid, me_readdatatag, me_readdata
  );

  modport master (
    output req_valid, req_writeenable, req_address, req_writedata,
           req_sizelg2, req_rd, req_signextend,
    input  req_ready,
    input  mem_valid, mem_writeenable, mem_address, mem_writedata,
           mem_sizelg2, mem_readtag, mem_readsignextend,
    output me_ready, me_readdatavalid, me_readdatatag, me_readdata
  );
endinterface

// File: rtl/yarvi_ls_fifo.sv
// Small synchronous FIFO for queued memory requests; DEPTH must be a power of two
// so the pointers wrap naturally.
module yarvi_ls_fifo #(
  parameter int DEPTH = 4,
  parameter int PTRW  = 2,
  parameter int W     = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         enq,
  input  logic         deq,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  logic [W-1:0]    store [DEPTH];
  logic [PTRW-1:0] rd_ptr;
  logic [PTRW-1:0] wr_ptr;
  logic [PTRW:0]   count;
  logic            do_enq;
  logic            do_deq;

  assign full   = (count == (PTRW+1)'(DEPTH));
  assign empty  = (count == '0);
  assign do_enq = enq & ~full;
  assign do_deq = deq & ~empty;
  assign dout   = store[rd_ptr];

  // Storage is cleared too so the head fields read as zero straight after reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) store[i] <= '0;
    end else begin
      if (do_enq) begin
        store[wr_ptr] <= din;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (do_deq) rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_enq, do_deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/yarvi_ls_issue.sv
// Load/store issue: request FIFO toward the memory stage, per-register load
// scoreboard and registered writeback. Define YARVI_LS_BYPASS_EN for empty-FIFO bypass.
module yarvi_ls_issue
  import yarvi_ls_issue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTRW  = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  yarvi_ls_issue_if.slave  ls,
  output logic             wb_valid,
  output logic [4:0]       wb_rd,
  output logic [XW-1:0]    wb_val,
  output logic [31:0]      pending,
  output logic             err_unexpected
);

  ls_entry_t   req_entry;
  ls_entry_t   head;
  ls_entry_t   issue;
  logic        fifo_full;
  logic        fifo_empty;
  logic        is_load;
  logic        rd_busy;
  logic        accept;
  logic        take_bypass;
  logic        enq;
  logic        deq;
  logic        rsp_hit;
  logic        rsp_miss;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;
  logic [31:0] pending_next;

  assign is_load = ~ls.req_writeenable;
  // A load whose destination still waits on an older load must not overtake it.
  assign rd_busy      = is_load & (ls.req_rd != 5'd0) & pending[ls.req_rd];
  assign ls.req_ready = ~fifo_full & ~rd_busy;
  assign accept       = ls.req_valid & ls.req_ready;

  always_comb begin
    req_entry            = '0;
    req_entry.we         = ls.req_writeenable;
    req_entry.address    = ls.req_address;
    req_entry.data       = ls.req_writedata;
    req_entry.sizelg2    = ls.req_sizelg2;
    req_entry.tag        = read_tag(ls.req_writeenable, ls.req_rd);
    req_entry.signextend = ls.req_signextend;
  end

`ifdef YARVI_LS_BYPASS_EN
  assign take_bypass  = fifo_empty & accept & ls.me_ready;
  assign issue        = (fifo_empty & accept) ? req_entry : head;
  assign ls.mem_valid = ~fifo_empty | accept;
`else
  assign take_bypass  = 1'b0;
  assign issue        = head;
  assign ls.mem_valid = ~fifo_empty;
`endif

  assign enq = accept & ~take_bypass;
  assign deq = ~fifo_empty & ls.me_ready;

  yarvi_ls_fifo #(
    .DEPTH (DEPTH),
    .PTRW  (PTRW),
    .W     (ENTRY_W)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .enq     (enq),
    .deq     (deq),
    .din     (req_entry),
    .dout    (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign ls.mem_writeenable    = issue.we;
  assign ls.mem_address        = issue.address;
  assign ls.mem_writedata      = issue.data;
  assign ls.mem_sizelg2        = issue.sizelg2;
  assign ls.mem_readtag        = issue.tag;
  assign ls.mem_readsignextend = issue.signextend;

  assign rsp_hit  = ls.me_readdatavalid & (ls.me_readdatatag != 5'd0) &  pending[ls.me_readdatatag];
  assign rsp_miss = ls.me_readdatavalid & (ls.me_readdatatag != 5'd0) & ~pending[ls.me_readdatatag];

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (accept && is_load && (ls.req_rd != 5'd0)) set_mask[ls.req_rd] = 1'b1;
    if (rsp_hit) clr_mask[ls.me_readdatatag] = 1'b1;
  end

  // x0 is never tracked, so bit 0 is forced clear.
  assign pending_next = (pending | set_mask) & ~clr_mask & ~32'd1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending        <= '0;
      wb_valid       <= 1'b0;
      wb_rd          <= '0;
      wb_val         <= '0;
      err_unexpected <= 1'b0;
    end else begin
      pending  <= pending_next;
      wb_valid <= rsp_hit;
      if (rsp_hit) begin
        wb_rd  <= ls.me_readdatatag;
        wb_val <= ls.me_readdata;
      end
      if (rsp_miss) err_unexpected <= 1'b1;
    end
  end

endmodule

// File: tb/tb_yarvi_ls_issue.sv
// Bench for yarvi_ls_issue: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_yarvi_ls_issue;
  import yarvi_ls_issue_pkg::*;

  localparam int DEPTH = 4;
`ifdef YARVI_LS_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  yarvi_ls_issue_if ls();
  logic          wb_valid;
  logic [4:0]    wb_rd;
  logic [XW-1:0] wb_val;
  logic [31:0]   pending;
  logic          err_unexpected;

  yarvi_ls_issue #(.DEPTH(DEPTH), .PTRW(2)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ls             (ls),
    .wb_valid       (wb_valid),
    .wb_rd          (wb_rd),
    .wb_val         (wb_val),
    .pending        (pending),
    .err_unexpected (err_unexpected)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_req(input logic v, input logic we, input logic [4:0] rd,
                           input logic [VW-1:0] addr, input logic [XW-1:0] data,
                           input logic [1:0] sz, input logic sx);
    ls.req_valid       = v;
    ls.req_writeenable = we;
    ls.req_rd          = rd;
    ls.req_address     = addr;
    ls.req_writedata   = data;
    ls.req_sizelg2     = sz;
    ls.req_signextend  = sx;
  endtask

  task automatic drive_me(input logic rdy, input logic rv, input logic [4:0] tag,
                          input logic [XW-1:0] d);
    ls.me_ready         = rdy;
    ls.me_readdatavalid = rv;
    ls.me_readdatatag   = tag;
    ls.me_readdata      = d;
  endtask

  task automatic idle(input logic rdy);
    drive_req(1'b0, 1'b0, 5'd0, '0, '0, 2'd0, 1'b0);
    drive_me(rdy, 1'b0, 5'd0, '0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    idle(1'b0);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Table vectors: inputs for one cycle, then expected pre-edge and post-edge outputs.
  typedef struct {
    logic          rv, we;
    logic [4:0]    rd;
    logic [63:0]   addr;
    logic          mr, sv;
    logic [4:0]    st;
    logic [63:0]   sd;
    logic          rdy, mv, mvb;
    logic [31:0]   pend;
    logic          wbv;
    logic [4:0]    wbrd;
    logic [63:0]   wbval;
    logic          err;
  } vec_t;

  vec_t tbl[17];

  typedef struct packed {
    logic          we;
    logic [VW-1:0] addr;
    logic [XW-1:0] data;
    logic [1:0]    sz;
    logic [4:0]    tag;
    logic          sx;
  } mreq_t;

  mreq_t mq[$];
  bit    m_pend[32];
  logic  m_wbv, m_err;
  logic [4:0]    m_wbrd;
  logic [XW-1:0] m_wbval;

  function automatic logic [31:0] pend_vec();
    logic [31:0] v;
    v = '0;
    for (int r = 0; r < 32; r++) v[r] = m_pend[r];
    return v;
  endfunction

  initial begin
    idle(1'b0);
    reset_n = 1'b0;
    #2;
    chk("rst_mem_valid", ls.mem_valid, 1'b0);
    chk("rst_pending", pending, 32'd0);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_wb_rd", wb_rd, 5'd0);
    chk("rst_wb_val", wb_val, 64'd0);
    chk("rst_err", err_unexpected, 1'b0);
    chk("rst_req_ready", ls.req_ready, 1'b1);
    @(negedge clock);
    reset_n = 1'b1;

    tbl[0]  = '{0,0,0,64'h0,  1,0,0,64'h0,                   1,0,0,32'h0, 0,0,64'h0,                   0};
    tbl[1]  = '{1,0,5,64'h100,1,0,0,64'h0,                   1,0,1,32'h20,0,0,64'h0,                   0};
    tbl[2]  = '{0,0,0,64'h0,  1,0,0,64'h0,                   1,1,0,32'h20,0,0,64'h0,                   0};
    tbl[3]  = '{0,0,0,64'h0,  1,1,5,64'hDEADBEEF_00000001,   1,0,0,32'h0, 1,5,64'hDEADBEEF_00000001,   0};
    tbl[4]  = '{0,0,0,64'h0,  1,0,0,64'h0,                   1,0,0,32'h0, 0,5,64'hDEADBEEF_00000001,   0};
    tbl[5]  = '{1,0,0,64'h200,1,0,0,64'h0,                   1,0,1,32'h0, 0,5,64'hDEADBEEF_00000001,   0};
    tbl[6]  = '{0,0,0,64'h0,  1,1,0,64'h1234,                1,1,0,32'h0, 0,5,64'hDEADBEEF_00000001,   0};
    tbl[7]  = '{0,0,0,64'h0,  1,1,9,64'h5555,                1,0,0,32'h0, 0,5,64'hDEADBEEF_00000001,   1};
    tbl[8]  = '{0,0,0,64'h0,  1,0,0,64'h0,                   1,0,0,32'h0, 0,5,64'hDEADBEEF_00000001,   1};
    tbl[9]  = '{1,0,7,64'h700,1,0,0,64'h0,                   1,0,1,32'h80,0,5,64'hDEADBEEF_00000001,   1};
    tbl[10] = '{1,0,7,64'h708,1,1,7,64'h77,                  0,1,0,32'h0, 1,7,64'h77,                  1};
    tbl[11] = '{1,0,7,64'h708,1,0,0,64'h0,                   1,0,1,32'h80,0,7,64'h77,                  1};
    tbl[12] = '{0,0,0,64'h0,  1,1,7,64'h99,                  1,1,0,32'h0, 1,7,64'h99,                  1};
    tbl[13] = '{0,0,0,64'h0,  1,0,0,64'h0,                   1,0,0,32'h0, 0,7,64'h99,                  1};
    tbl[14] = '{1,1,3,64'h800,0,0,0,64'h0,                   1,0,1,32'h0, 0,7,64'h99,                  1};
    tbl[15] = '{0,0,0,64'h0,  1,0,0,64'h0,                   1,1,1,32'h0, 0,7,64'h99,                  1};
    tbl[16] = '{0,0,0,64'h0,  1,0,0,64'h0,                   1,0,0,32'h0, 0,7,64'h99,                  1};

    for (int i = 0; i < 17; i++) begin
      @(negedge clock);
      drive_req(tbl[i].rv, tbl[i].we, tbl[i].rd, tbl[i].addr, 64'(i), 2'd3, 1'b0);
      drive_me(tbl[i].mr, tbl[i].sv, tbl[i].st, tbl[i].sd);
      #1;
      chk($sformatf("tbl%0d_req_ready", i), ls.req_ready, tbl[i].rdy);
      chk($sformatf("tbl%0d_mem_valid", i), ls.mem_valid, BYP ? tbl[i].mvb : tbl[i].mv);
      @(posedge clock);
      #1;
      chk($sformatf("tbl%0d_pending", i), pending, tbl[i].pend);
      chk($sformatf("tbl%0d_wb_valid", i), wb_valid, tbl[i].wbv);
      chk($sformatf("tbl%0d_wb_rd", i), wb_rd, tbl[i].wbrd);
      chk($sformatf("tbl%0d_wb_val", i), wb_val, tbl[i].wbval);
      chk($sformatf("tbl%0d_err", i), err_unexpected, tbl[i].err);
    end

    // Reset asserted with two loads queued and the error flag already set.
    @(negedge clock);
    drive_req(1'b1, 1'b0, 5'd3, 64'h30, 64'h0, 2'd3, 1'b0);
    drive_me(1'b0, 1'b0, 5'd0, '0);
    @(negedge clock);
    drive_req(1'b1, 1'b0, 5'd4, 64'h40, 64'h0, 2'd3, 1'b0);
    @(negedge clock);
    idle(1'b0);
    #1;
    chk("mid_pending_before", pending, 32'h18);
    chk("mid_mem_valid_before", ls.mem_valid, 1'b1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_mem_valid", ls.mem_valid, 1'b0);
    chk("mid_rst_mem_address", ls.mem_address, 64'h0);
    chk("mid_rst_mem_readtag", ls.mem_readtag, 5'd0);
    chk("mid_rst_pending", pending, 32'd0);
    chk("mid_rst_wb", {wb_valid, wb_rd, wb_val}, '0);
    chk("mid_rst_err", err_unexpected, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;

    // Fill with four stores while the memory stage is stalled.
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      drive_req(1'b1, 1'b1, 5'(i + 1), 64'(i * 8), 64'(100 + i), 2'd3, 1'b0);
      drive_me(1'b0, 1'b0, 5'd0, '0);
      #1;
      chk($sformatf("fill%0d_req_ready", i), ls.req_ready, 1'b1);
    end
    @(negedge clock);
    drive_req(1'b1, 1'b1, 5'd9, 64'h20, 64'd200, 2'd3, 1'b0);
    drive_me(1'b0, 1'b0, 5'd0, '0);
    #1;
    chk("full_req_ready", ls.req_ready, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (i != 0) drive_req(1'b0, 1'b0, 5'd0, '0, '0, 2'd0, 1'b0);
      drive_me(1'b1, 1'b0, 5'd0, '0);
      #1;
      if (i == 0) chk("full_deq_req_ready", ls.req_ready, 1'b0);
      chk($sformatf("drain%0d", i),
          {ls.mem_valid, ls.mem_writeenable, ls.mem_address, ls.mem_writedata, ls.mem_readtag},
          {1'b1, 1'b1, 64'(i * 8), 64'(100 + i), 5'd0});
    end
    @(negedge clock);
    idle(1'b1);
    #1;
    chk("drain_empty", ls.mem_valid, 1'b0);

    // Issue latency of a lone load to x3, then its writeback.
    @(negedge clock);
    drive_req(1'b1, 1'b0, 5'd3, 64'h300, 64'h0, 2'd3, 1'b1);
    drive_me(1'b1, 1'b0, 5'd0, '0);
    #1;
    chk("lat_accept_cycle", {ls.mem_valid, ls.mem_valid ? ls.mem_readtag : 5'h1f},
        BYP ? {1'b1, 5'd3} : {1'b0, 5'h1f});
    @(negedge clock);
    idle(1'b1);
    #1;
    chk("lat_next_cycle", {ls.mem_valid, ls.mem_valid ? ls.mem_readtag : 5'h1f},
        BYP ? {1'b0, 5'h1f} : {1'b1, 5'd3});
    chk("lat_pending", pending, 32'h8);
    @(negedge clock);
    drive_me(1'b1, 1'b1, 5'd3, 64'hCAFE);
    @(posedge clock);
    #1;
    chk("lat_wb", {wb_valid, wb_rd, wb_val, pending}, {1'b1, 5'd3, 64'hCAFE, 32'd0});

    // Load to x0 carries tag 0 and is never tracked.
    @(negedge clock);
    drive_req(1'b1, 1'b0, 5'd0, 64'h10, 64'h0, 2'd2, 1'b0);
    drive_me(1'b1, 1'b0, 5'd0, '0);
    #1;
    chk("x0_accept_cycle", {ls.mem_valid, ls.mem_valid ? ls.mem_readtag : 5'h1f},
        BYP ? {1'b1, 5'd0} : {1'b0, 5'h1f});
    @(negedge clock);
    idle(1'b1);
    #1;
    chk("x0_next_cycle", {ls.mem_valid, ls.mem_valid ? ls.mem_readtag : 5'h1f},
        BYP ? {1'b0, 5'h1f} : {1'b1, 5'd0});
    chk("x0_pending", pending, 32'd0);

    // Randomized run against the reference model.
    do_reset();
    mq.delete();
    for (int r = 0; r < 32; r++) m_pend[r] = 1'b0;
    m_wbv = 1'b0; m_err = 1'b0; m_wbrd = '0; m_wbval = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      logic rv, we, sx, mr, sv, exp_rdy, acc, ev, hit, miss;
      logic [4:0] rd, st;
      logic [1:0] sz;
      logic [63:0] addr, data, sd;
      mreq_t r, eh;
      int cand[$];
      @(negedge clock);
      rv   = 1'($urandom_range(0, 1));
      we   = ($urandom_range(0, 3) == 0);
      rd   = 5'($urandom_range(0, 7));
      addr = {$urandom, $urandom};
      data = {$urandom, $urandom};
      sz   = 2'($urandom_range(0, 3));
      sx   = 1'($urandom_range(0, 1));
      mr   = ($urandom_range(0, 3) != 0);
      sv   = ($urandom_range(0, 2) == 0);
      sd   = {$urandom, $urandom};
      for (int k = 1; k < 32; k++) if (m_pend[k]) cand.push_back(k);
      if ($urandom_range(0, 59) == 0) st = 5'($urandom_range(0, 31));
      else if (cand.size() == 0) st = 5'd0;
      else st = 5'(cand[$urandom_range(0, cand.size() - 1)]);
      drive_req(rv, we, rd, addr, data, sz, sx);
      drive_me(mr, sv, st, sd);
      #1;
      exp_rdy = (mq.size() < DEPTH) && !(!we && rd != 5'd0 && m_pend[rd]);
      chk("rnd_req_ready", ls.req_ready, exp_rdy);
      acc = rv && exp_rdy;
      r = '{we, addr, data, sz, we ? 5'd0 : rd, sx};
      ev = 1'b0;
      eh = '0;
      if (mq.size() > 0) begin ev = 1'b1; eh = mq[0]; end
      else if (BYP && acc) begin ev = 1'b1; eh = r; end
      chk("rnd_mem_valid", ls.mem_valid, ev);
      if (ev)
        chk("rnd_mem_fields",
            {ls.mem_writeenable, ls.mem_address, ls.mem_writedata, ls.mem_sizelg2,
             ls.mem_readtag, ls.mem_readsignextend}, eh);
      if (mq.size() > 0) begin
        if (mr) void'(mq.pop_front());
        if (acc) mq.push_back(r);
      end else if (acc && !(BYP && mr)) begin
        mq.push_back(r);
      end
      hit  = sv && st != 5'd0 && m_pend[st];
      miss = sv && st != 5'd0 && !m_pend[st];
      if (hit) m_pend[st] = 1'b0;
      if (acc && !we && rd != 5'd0) m_pend[rd] = 1'b1;
      m_wbv = hit;
      if (hit) begin m_wbrd = st; m_wbval = sd; end
      if (miss) m_err = 1'b1;
      @(posedge clock);
      #1;
      chk("rnd_wb", {wb_valid, wb_rd, wb_val}, {m_wbv, m_wbrd, m_wbval});
      chk("rnd_pending", pending, pend_vec());
      chk("rnd_err", err_unexpected, m_err);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
